// File: rtl/nlp_pkg.sv
// Shared types and constants for the next-line predictor: the prediction record,
// the IF3 training record, the stored entry payload, and the bimodal counter constants.
package nlp_pkg;

  localparam logic [1:0] BIM_WEAK_NT  = 2'b01;
  localparam logic [1:0] BIM_STRONG_T = 2'b11;

  typedef struct packed {
    logic        valid;
    logic        taken;
    logic [31:0] target;
    logic [1:0]  bim_state;
  } nlp_info_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] target;
    logic [1:0]  bim_state;
    logic        should_take;
  } nlp_update_t;

  // Tag width is a module parameter, so the tag lives in its own array beside this payload
  typedef struct packed {
    logic [31:0] target;
    logic [1:0]  bim;
  } nlp_entry_t;

  function automatic nlp_info_t entry_to_info(input nlp_entry_t e);
    nlp_info_t r;
    r.valid     = 1'b1;
    r.taken     = e.bim[1];
    r.target    = e.target;
    r.bim_state = e.bim;
    return r;
  endfunction

endpackage

// File: rtl/nlp_bim_counter.sv
// Combinational 2-bit saturating counter step: increments toward 11 on take,
// decrements toward 00 otherwise.
module nlp_bim_counter
  import nlp_pkg::*;
(
  input  logic [1:0] state_i,
  input  logic       take_i,
  output logic [1:0] state_o
);

  always_comb begin
    state_o = state_i;
    if (take_i) begin
      if (state_i != BIM_STRONG_T) state_o = state_i + 2'd1;
    end else begin
      if (state_i != 2'b00) state_o = state_i - 2'd1;
    end
  end

endmodule

// File: rtl/nlp_predictor.sv
// Next-line predictor: tagged target table with bimodal counters, two lookup slots
// registered one cycle later. Define NLP_BYPASS_EN to forward same-cycle updates into lookups.
module nlp_predictor
  import nlp_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TAG_W   = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lookup_valid,
  input  logic [31:0] lookup_pc,
  input  logic        hold,
  input  logic        flush,
  output nlp_info_t   info0,
  output nlp_info_t   info1,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic [1:0]  upd_bim_state,
  input  logic        upd_should_take
);

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q  [ENTRIES];
  nlp_entry_t         data_q [ENTRIES];

  nlp_info_t info0_q, info0_d, info1_q, info1_d;
  nlp_info_t res0, res1;

  nlp_update_t      upd;
  nlp_entry_t       upd_entry;
  logic [1:0]       bim_next;
  logic [31:0]      pc1;
  logic [IDX_W-1:0] idx0, idx1, upd_idx;
  logic [TAG_W-1:0] tag0, tag1, upd_tag;
  logic             hit0, hit1;
  logic             unused_pc_bits;

  assign upd = '{valid: upd_valid, pc: upd_pc, target: upd_target,
                 bim_state: upd_bim_state, should_take: upd_should_take};

  nlp_bim_counter u_bim (
    .state_i (upd.bim_state),
    .take_i  (upd.should_take),
    .state_o (bim_next)
  );

  assign upd_entry = '{target: upd.target, bim: bim_next};

  assign pc1     = lookup_pc + 32'd4;
  assign idx0    = lookup_pc[IDX_W+1:2];
  assign idx1    = pc1[IDX_W+1:2];
  assign upd_idx = upd.pc[IDX_W+1:2];
  assign tag0    = lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign tag1    = pc1[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_tag = upd.pc[IDX_W+TAG_W+1:IDX_W+2];

  assign unused_pc_bits = ^{lookup_pc, pc1, upd.pc};

  assign hit0 = lookup_valid && valid_q[idx0] && (tag_q[idx0] == tag0);
  assign hit1 = lookup_valid && valid_q[idx1] && (tag_q[idx1] == tag1);

  always_comb begin
    res0 = hit0 ? entry_to_info(data_q[idx0]) : '0;
    res1 = hit1 ? entry_to_info(data_q[idx1]) : '0;
`ifdef NLP_BYPASS_EN
    if (lookup_valid && upd.valid && (upd_idx == idx0) && (upd_tag == tag0))
      res0 = entry_to_info(upd_entry);
    if (lookup_valid && upd.valid && (upd_idx == idx1) && (upd_tag == tag1))
      res1 = entry_to_info(upd_entry);
`endif
  end

  always_comb begin
    info0_d = res0;
    info1_d = res1;
    if (flush) begin
      info0_d = '0;
      info1_d = '0;
    end else if (hold) begin
      info0_d = info0_q;
      info1_d = info1_q;
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (upd.valid) valid_d[upd_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      info0_q <= '0;
      info1_q <= '0;
    end else begin
      valid_q <= valid_d;
      info0_q <= info0_d;
      info1_q <= info1_d;
    end
  end

  // Payload storage is deliberately unreset; valid_q alone gates hits.
  always_ff @(posedge clk) begin
    if (upd.valid) begin
      tag_q[upd_idx]  <= upd_tag;
      data_q[upd_idx] <= upd_entry;
    end
  end

  assign info0 = info0_q;
  assign info1 = info1_q;

endmodule

// File: tb/tb_nlp_predictor.sv
// Self-checking bench for nlp_predictor: directed scenarios plus randomized traffic
// compared against a behavioural table model.
module tb_nlp_predictor;
  import nlp_pkg::*;

  localparam int ENTRIES = 64;
  localparam int IDX_W   = $clog2(ENTRIES);
  localparam int TAG_W   = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        hold;
  logic        flush;
  nlp_info_t   info0, info1;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic [1:0]  upd_bim_state;
  logic        upd_should_take;

  nlp_predictor #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .lookup_valid    (lookup_valid),
    .lookup_pc       (lookup_pc),
    .hold            (hold),
    .flush           (flush),
    .info0           (info0),
    .info1           (info1),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_target      (upd_target),
    .upd_bim_state   (upd_bim_state),
    .upd_should_take (upd_should_take)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference table: indexed by plain arithmetic on the PC
  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int unsigned m_bim   [ENTRIES];
  nlp_info_t   exp0, exp1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic int unsigned m_idx(input logic [31:0] pc);
    return (pc / 4) % ENTRIES;
  endfunction

  function automatic int unsigned m_tagof(input logic [31:0] pc);
    return (pc / (4 * ENTRIES)) % (1 << TAG_W);
  endfunction

  function automatic int unsigned m_step(input int unsigned b, input bit take);
    if (take) return (b >= 3) ? 3 : b + 1;
    return (b == 0) ? 0 : b - 1;
  endfunction

  function automatic nlp_info_t mk_info(input logic [31:0] tgt, input int unsigned b);
    nlp_info_t r;
    r.valid     = 1'b1;
    r.taken     = (b >= 2);
    r.target    = tgt;
    r.bim_state = 2'(b);
    return r;
  endfunction

  function automatic nlp_info_t m_lookup(input logic [31:0] pc);
    int unsigned i;
    i = m_idx(pc);
    if (!lookup_valid) return '0;
`ifdef NLP_BYPASS_EN
    if (upd_valid && m_idx(upd_pc) == i && m_tagof(upd_pc) == m_tagof(pc))
      return mk_info(upd_target, m_step(upd_bim_state, upd_should_take));
`endif
    if (m_valid[i] && m_tag[i] == m_tagof(pc)) return mk_info(m_tgt[i], m_bim[i]);
    return '0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    exp0 = '0;
    exp1 = '0;
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then compare.
  task automatic cyc(input logic lv, input logic [31:0] lpc, input logic h, input logic f,
                     input logic uv, input logic [31:0] upc, input logic [31:0] ut,
                     input logic [1:0] ub, input logic tk);
    nlp_info_t n0, n1;
    int unsigned i;
    lookup_valid = lv; lookup_pc = lpc; hold = h; flush = f;
    upd_valid = uv; upd_pc = upc; upd_target = ut; upd_bim_state = ub; upd_should_take = tk;
    if (f) begin
      n0 = '0; n1 = '0;
    end else if (h) begin
      n0 = exp0; n1 = exp1;
    end else begin
      n0 = m_lookup(lpc);
      n1 = m_lookup(lpc + 32'd4);
    end
    @(posedge clk);
    if (uv) begin
      i = m_idx(upc);
      m_valid[i] = 1'b1;
      m_tag[i]   = m_tagof(upc);
      m_tgt[i]   = ut;
      m_bim[i]   = m_step(ub, tk);
    end
    exp0 = n0;
    exp1 = n1;
    #1;
    check("info0", info0, exp0);
    check("info1", info1, exp1);
  endtask

  task automatic look(input logic [31:0] pc);
    cyc(1'b1, pc, 1'b0, 1'b0, 1'b0, '0, '0, 2'b00, 1'b0);
  endtask

  task automatic upd(input logic [31:0] pc, input logic [31:0] t, input logic [1:0] b, input logic tk);
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1, pc, t, b, tk);
  endtask

  logic [31:0] pool [8];
  logic [31:0] rpc, upc;
  nlp_info_t   want;

  initial begin
    rst = 1'b0;
    lookup_valid = 1'b0; lookup_pc = '0; hold = 1'b0; flush = 1'b0;
    upd_valid = 1'b0; upd_pc = '0; upd_target = '0; upd_bim_state = '0; upd_should_take = 1'b0;
    model_reset();
    #12;
    check("reset_info0", info0, '0);
    check("reset_info1", info1, '0);
    @(negedge clk);
    rst = 1'b1;

    look(32'h8000_0000);
    check("first_miss0", info0, '0);
    check("first_miss1", info1, '0);

    upd(32'h8000_0004, 32'h8000_0100, 2'b01, 1'b1);
    look(32'h8000_0000);
    want = '{valid: 1'b1, taken: 1'b1, target: 32'h8000_0100, bim_state: 2'b10};
    check("train_hit1", info1, want);
    check("train_miss0", info0, '0);

    upd(32'h8000_0004, 32'h8000_0100, 2'b11, 1'b1);
    look(32'h8000_0000);
    want = '{valid: 1'b1, taken: 1'b1, target: 32'h8000_0100, bim_state: 2'b11};
    check("sat_high", info1, want);

    upd(32'h8000_0004, 32'h8000_0100, 2'b00, 1'b0);
    look(32'h8000_0000);
    want = '{valid: 1'b1, taken: 1'b0, target: 32'h8000_0100, bim_state: 2'b00};
    check("sat_low", info1, want);

    upd(32'h8000_0010, 32'h1111_0000, 2'b01, 1'b1);
    upd(32'h8000_0010 + ENTRIES * 4, 32'h2222_0000, 2'b01, 1'b1);
    look(32'h8000_0010);
    check("alias_evicted", info0, '0);
    look(32'h8000_0010 + ENTRIES * 4);
    want = '{valid: 1'b1, taken: 1'b1, target: 32'h2222_0000, bim_state: 2'b10};
    check("alias_new", info0, want);

    cyc(1'b1, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 32'h9000_0000, 2'b01, 1'b1);
    want = '{valid: 1'b1, taken: 1'b1, target: 32'h9000_0000, bim_state: 2'b10};
`ifdef NLP_BYPASS_EN
    check("same_cycle", info0, want);
`else
    check("same_cycle", info0, '0);
`endif
    look(32'h8000_0000);
    check("after_write", info0, want);

    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 32'h8000_0040 + 32'(k * 8), 1'b1, 1'b0, 1'b0, '0, '0, 2'b00, 1'b0);
      check("hold_keep", info0, want);
    end
    cyc(1'b1, 32'h8000_0000, 1'b1, 1'b1, 1'b0, '0, '0, 2'b00, 1'b0);
    check("flush_hold0", info0, '0);
    check("flush_hold1", info1, '0);

    for (int k = 0; k < 8; k++) pool[k] = 32'h8000_0000 + 32'(k * 4) + 32'($urandom_range(0, 1) * ENTRIES * 4);
    for (int n = 0; n < 400; n++) begin
      rpc = pool[$urandom_range(0, 7)];
      upc = pool[$urandom_range(0, 7)];
      cyc(1'($urandom_range(0, 3) != 0), rpc,
          1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 14) == 0),
          1'($urandom_range(0, 2) == 0), upc, $urandom,
          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    look(32'h8000_0000);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_info0", info0, '0);
    check("midrst_info1", info1, '0);
    model_reset();
    #1;
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      look(pool[k]);
      check("post_rst_miss", info0, '0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
